// File: rtl/param_fir.sv
`default_nettype none
// ============================================================================
// Module      : param_fir
// Description : Parameterised unsigned FIR filter with a three-register
//               pipeline (delay line / products / rounded-saturated sum),
//               fill tracking, synchronous flush and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module param_fir #(
    parameter int                        DATA_W = 8,
    parameter int                        NTAPS  = 5,
    parameter int                        COEF_W = 8,
    parameter logic [NTAPS*COEF_W-1:0]   COEFS  = {8'd1, 8'd2, 8'd3, 8'd2, 8'd1},
    parameter int                        SHIFT  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam int c_PROD_W = DATA_W + COEF_W;
    localparam int c_ACC_W  = c_PROD_W + $clog2(NTAPS);
    // One extra bit so the rounding constant can never wrap the sum.
    localparam int c_RND_W  = c_ACC_W + 1;
    localparam int c_CNT_W  = $clog2(NTAPS + 1);

    logic [DATA_W-1:0]   r_x [NTAPS];
    logic [c_PROD_W-1:0] r_p [NTAPS];
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_v1;
    logic                r_v2;

    logic                w_accept;
    logic                w_fills;
    logic [c_ACC_W-1:0]  w_sum;
    logic [c_RND_W-1:0]  w_rnd;
    logic [c_RND_W-1:0]  w_shr;
    logic [DATA_W-1:0]   w_sat;

    // clear takes priority, so a sample presented with clear is dropped.
    assign w_accept = in_valid & ~clear;
    // The accepted sample completes the window when NTAPS-1 are already held.
    assign w_fills  = (r_cnt >= c_CNT_W'(NTAPS - 1));

    // S1: delay line, fill counter and first-stage valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
            r_cnt <= '0;
            r_v1  <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < NTAPS; k++) r_x[k] <= '0;
            r_cnt <= '0;
            r_v1  <= 1'b0;
        end else begin
            r_v1 <= w_accept & w_fills;
            if (w_accept) begin
                r_x[0] <= in_data;
                for (int k = 1; k < NTAPS; k++) r_x[k] <= r_x[k-1];
                if (r_cnt != c_CNT_W'(NTAPS)) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // S2: per-tap products; they track the delay line, the valid bit qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++) r_p[k] <= '0;
            r_v2 <= 1'b0;
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                r_p[k] <= c_PROD_W'(r_x[k]) * c_PROD_W'(COEFS[k*COEF_W +: COEF_W]);
            end
            r_v2 <= clear ? 1'b0 : r_v1;
        end
    end

    // Adder tree over all products, wide enough to never overflow.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_sum = w_sum + c_ACC_W'(r_p[k]);
        end
    end

    generate
        if (SHIFT > 0) begin : g_round
            assign w_rnd = c_RND_W'(w_sum) + (c_RND_W'(1) << (SHIFT - 1));
        end else begin : g_no_round
            assign w_rnd = c_RND_W'(w_sum);
        end
    endgenerate

    assign w_shr = w_rnd >> SHIFT;
    assign w_sat = (|w_shr[c_RND_W-1:DATA_W]) ? {DATA_W{1'b1}} : w_shr[DATA_W-1:0];

    // S3: output register; data only moves on a valid result so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_v2;
            if (r_v2) out_data <= w_sat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_fir.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_fir
// Description : Directed self-checking bench for param_fir (default build and
//               an 8-tap unity-coefficient build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_fir;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       in_valid2;
    logic [7:0] in_data2;
    logic       out_valid2;
    logic [7:0] out_data2;

    int n_checks = 0;
    int n_fail   = 0;

    param_fir u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    param_fir #(
        .DATA_W (8),
        .NTAPS  (8),
        .COEF_W (8),
        .COEFS  ({8{8'd1}}),
        .SHIFT  (0)
    ) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid2),
        .in_data   (in_data2),
        .out_valid (out_valid2),
        .out_data  (out_data2)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
    endtask

    int imp [13] = '{0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0};
    int ev  [13] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int ed  [13] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 2, 1, 0, 0};

    initial begin
        int nv;
        int vstep;
        int vdata;
        clk       = 1'b0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_valid2 = 1'b0;
        in_data2  = '0;

        // Reset state, observed before any clock edge.
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_valid8", out_valid2, 0);
        chk("rst_data8", out_data2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse response.
        for (int i = 0; i < 13; i++) begin
            send(imp[i][7:0]);
            chk($sformatf("imp_v%0d", i), out_valid, ev[i]);
            chk($sformatf("imp_d%0d", i), out_data, ed[i]);
        end

        // Constant 16 -> (144+4)>>3 = 18.
        for (int j = 0; j < 8; j++) begin
            send(8'd16);
            if (j >= 6) begin
                chk("c16_v", out_valid, 1);
                chk("c16_d", out_data, 18);
            end
        end

        // Constant 255 -> 287 saturates to 255.
        for (int j = 0; j < 8; j++) begin
            send(8'd255);
            if (j >= 6) begin
                chk("c255_v", out_valid, 1);
                chk("c255_d", out_data, 255);
            end
        end

        // Fresh start, then priming with gaps: accepted on steps 0,2,4,6,8.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        nv    = 0;
        vstep = -1;
        vdata = -1;
        for (int s = 0; s < 16; s++) begin
            in_valid = (s < 9) && (s % 2 == 0);
            in_data  = 8'd8;
            step();
            if (out_valid) begin
                nv++;
                vstep = s;
                vdata = out_data;
            end
        end
        chk("gap_count", nv, 1);
        chk("gap_step", vstep, 10);
        chk("gap_data", vdata, 9);
        chk("gap_hold_d", out_data, 9);
        chk("gap_hold_v", out_valid, 0);

        // Clear while streaming; the clear-cycle sample is dropped.
        for (int j = 0; j < 7; j++) send(8'd16);
        chk("pre_clr_v", out_valid, 1);
        chk("pre_clr_d", out_data, 18);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd16;
        step();
        clear = 1'b0;
        chk("clr_v", out_valid, 0);
        chk("clr_d", out_data, 18);
        for (int n = 0; n < 7; n++) begin
            send(8'd16);
            chk($sformatf("clr_refill_v%0d", n), out_valid, (n == 6) ? 1 : 0);
            chk($sformatf("clr_refill_d%0d", n), out_data, 18);
        end

        // Asynchronous reset between edges mid-stream.
        send(8'd16);
        chk("pre_arst_v", out_valid, 1);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_v", out_valid, 0);
        chk("arst_d", out_data, 0);
        rst_n = 1'b1;
        for (int n = 0; n < 7; n++) begin
            send(8'd16);
            chk($sformatf("arst_refill_v%0d", n), out_valid, (n == 6) ? 1 : 0);
            chk($sformatf("arst_refill_d%0d", n), out_data, (n == 6) ? 18 : 0);
        end
        in_valid = 1'b0;

        // 8-tap unity build, SHIFT=0: 255*8 = 2040 saturates, 10*8 = 80.
        for (int j = 0; j < 10; j++) begin
            in_valid2 = 1'b1;
            in_data2  = 8'd255;
            step();
            if (j == 8) chk("t8_prime_v", out_valid2, 0);
            if (j == 9) begin
                chk("t8_255_v", out_valid2, 1);
                chk("t8_255_d", out_data2, 255);
            end
        end
        for (int j = 0; j < 10; j++) begin
            in_data2 = 8'd10;
            step();
            if (j == 9) begin
                chk("t8_10_v", out_valid2, 1);
                chk("t8_10_d", out_data2, 80);
            end
        end
        in_valid2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_fir.md
PARAM_FIR -- requirements
Module: param_fir

Interface
REQ-001 Parameter DATA_W, default 8: sample width in bits, unsigned.
REQ-002 Parameter NTAPS, default 5: tap count, legal range 2..16.
REQ-003 Parameter COEF_W, default 8: coefficient width in bits, unsigned.
REQ-004 Parameter COEFS, default {1,2,3,2,1}: packed NTAPS*COEF_W vector, tap k at bits [k*COEF_W +: COEF_W]. Tap 0 weights the newest sample.
REQ-005 Parameter SHIFT, default 3: right-shift applied to the accumulated sum, legal range 0..(DATA_W+COEF_W).
REQ-006 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 Port clear, input, 1 bit: synchronous flush of filter state.
REQ-009 Port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-010 Port in_data, input, DATA_W bits: new sample.
REQ-011 Port out_valid, output, 1 bit: out_data holds a new filtered sample.
REQ-012 Port out_data, output, DATA_W bits: filtered, rounded, saturated sample.

Function
REQ-013 The block SHALL hold an internal NTAPS-deep delay line x[0..NTAPS-1], with x[0] the newest sample.
- On a rising edge with in_valid=1 and clear=0: x[k] <= x[k-1], x[0] <= in_data.
- Otherwise the delay line holds.
REQ-014 The block SHALL be a 3-register pipeline: delay line (S1), registered products p[k]=x[k]*COEFS[k] (S2), registered rounded/saturated sum (S3).
- Latency: a sample accepted on edge E SHALL appear on out_data/out_valid after edge E+2.
REQ-015 A valid bit SHALL accompany each stage. The pipeline SHALL never stall and accepts one sample per clock.
REQ-016 Product width SHALL be DATA_W+COEF_W.
- Accumulator width SHALL be DATA_W+COEF_W+clog2(NTAPS), so no intermediate overflow occurs.
REQ-017 Rounding: when SHIFT>0, SHALL compute (sum + 2^(SHIFT-1)) >> SHIFT; when SHIFT=0, no rounding.
REQ-018 Saturation: a result above 2^DATA_W-1 SHALL produce out_data = 2^DATA_W-1.
REQ-019 A fill counter SHALL count accepted samples, saturating at NTAPS.
- The S1 valid SHALL be set only if the accepted sample makes the count reach NTAPS (full window).
- The first NTAPS-1 samples after reset or clear SHALL produce no out_valid.
REQ-020 out_valid SHALL be high for exactly one cycle per qualifying sample.
- out_data SHALL hold its last value while out_valid=0.
REQ-021 clear=1 on an edge SHALL zero the delay line, fill counter and all stage valid bits.
- out_data SHALL be left unchanged.
- In-flight results SHALL be discarded: no out_valid on the following two edges.
REQ-022 If clear=1 and in_valid=1 on the same edge, clear SHALL win and the sample SHALL be dropped.
REQ-023 in_valid gaps SHALL NOT disturb window contents. The output for a sample depends only on the last NTAPS accepted samples.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock edge, zero the delay line, products, fill counter, all valid bits, out_valid and out_data.
REQ-025 Reset asserted mid-stream SHALL discard all in-flight samples. Behaviour after release SHALL equal that after power-on reset.
REQ-026 The first edge after rst_n rises SHALL be a normal operating edge.

Verification (default parameters unless stated)
REQ-027 Impulse: in_valid=1 continuously, in_data 0,0,0,0,8,0,0,0,0 -> out_valid first rises 2 edges after the 5th sample, then out_data = 1,2,3,2,1,0,...
REQ-028 Constant 16 stream -> after priming out_data=18 every cycle ((144+4)>>3); constant 255 -> out_data=255 (2299>>3=287, saturated).
REQ-029 Priming and gaps: 5 samples of 8 with in_valid toggling 1,0,1,0,... -> exactly one out_valid, out_data=9, 2 edges after the 5th accepted sample.
REQ-030 Clear: stream of 16 running, clear=1 with in_valid=1 for one edge -> no out_valid for 2 edges; the next out_valid only after 5 new accepted samples; that sample is dropped.
REQ-031 Async reset: rst_n pulsed low between clock edges mid-stream -> out_valid and out_data are 0 before the next edge; re-priming needs 5 samples.
REQ-032 Parameter sweep: NTAPS=8, all COEFS=1, SHIFT=0, DATA_W=8, constant 255 -> out_data=255 (2040 saturated); constant 10 -> out_data=80.
